// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the IF/MEM-stage requesters, the port arbiter and the
// single-port unified memory. The arbiter uses the slave view; requesters and
// the memory together use the master view.
interface mem_port_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
);
  // Instruction-fetch requester (read-only)
  logic                  if_req_i;
  logic [ADDR_WIDTH-1:0] if_addr_i;
  logic                  if_gnt_o;
  logic                  if_rvalid_o;
  logic [DATA_WIDTH-1:0] if_rdata_o;

  // MEM-stage requester (load/store)
  logic                  dm_req_i;
  logic                  dm_we_i;
  logic [3:0]            dm_be_i;
  logic [ADDR_WIDTH-1:0] dm_addr_i;
  logic [DATA_WIDTH-1:0] dm_wdata_i;
  logic                  dm_gnt_o;
  logic                  dm_rvalid_o;
  logic [DATA_WIDTH-1:0] dm_rdata_o;

  // Memory side
  logic                  mem_en_o;
  logic                  mem_we_o;
  logic [3:0]            mem_be_o;
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic [DATA_WIDTH-1:0] mem_wdata_o;
  logic [DATA_WIDTH-1:0] mem_rdata_i;

  modport slave (
    input  if_req_i, if_addr_i,
    input  dm_req_i, dm_we_i, dm_be_i, dm_addr_i, dm_wdata_i,
    input  mem_rdata_i,
    output if_gnt_o, if_rvalid_o, if_rdata_o,
    output dm_gnt_o, dm_rvalid_o, dm_rdata_o,
    output mem_en_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o
  );

  modport master (
    output if_req_i, if_addr_i,
    output dm_req_i, dm_we_i, dm_be_i, dm_addr_i, dm_wdata_i,
    output mem_rdata_i,
    input  if_gnt_o, if_rvalid_o, if_rdata_o,
    input  dm_gnt_o, dm_rvalid_o, dm_rdata_o,
    input  mem_en_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one non-pipelined single-port memory between instruction
// fetch (read-only) and the MEM stage (load/store). MEM stage wins by default;
// a starvation counter forces an IF grant after STARVE_LIMIT denied cycles.
// One access in flight; its response returns MEM_LAT cycles after issue.
module mem_port_arbiter #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 10,
  parameter int MEM_LAT      = 1,
  parameter int STARVE_LIMIT = 4
) (
  input logic               clk,
  input logic               rst_n,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_DM   = 2'd2
  } owner_t;

  localparam int CNT_W = (MEM_LAT < 2) ? 1 : $clog2(MEM_LAT + 1);
  localparam int STV_W = (STARVE_LIMIT < 2) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LAT_INIT = CNT_W'(MEM_LAT);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [STV_W-1:0] STV_MAX  = STV_W'(STARVE_LIMIT);
  localparam logic [STV_W-1:0] STV_ONE  = STV_W'(1);

  state_t           state_q;
  owner_t           owner_q;
  logic [CNT_W-1:0] busy_cnt_q;
  logic             store_q;
  logic [STV_W-1:0] starve_cnt_q;

  logic done;
  logic port_free;
  logic if_priority;
  logic gnt_if;
  logic gnt_dm;
  logic issue;

  // Arbitration: the port is free when idle or in the completion cycle, so
  // a new access can be issued back-to-back with the one finishing.
  always_comb begin
    done        = (state_q == ST_BUSY) && (busy_cnt_q == CNT_ONE);
    port_free   = rst_n && ((state_q == ST_IDLE) || done);
    if_priority = bus.if_req_i && (starve_cnt_q == STV_MAX);
    gnt_dm      = port_free && bus.dm_req_i && !if_priority;
    gnt_if      = port_free && bus.if_req_i && !gnt_dm;
    issue       = gnt_if || gnt_dm;
  end

  // Grant, memory strobe and response outputs derived from the arbitration
  // result and the registered owner of the access in flight.
  always_comb begin
    bus.if_gnt_o    = gnt_if;
    bus.dm_gnt_o    = gnt_dm;
    bus.mem_en_o    = issue;
    bus.mem_we_o    = gnt_dm && bus.dm_we_i;
    bus.mem_be_o    = gnt_dm ? bus.dm_be_i : 4'b0000;
    bus.mem_addr_o  = gnt_dm ? bus.dm_addr_i :
                      (gnt_if ? bus.if_addr_i : {ADDR_WIDTH{1'b0}});
    bus.mem_wdata_o = gnt_dm ? bus.dm_wdata_i : {DATA_WIDTH{1'b0}};
    bus.if_rvalid_o = done && (owner_q == OWN_IF);
    bus.dm_rvalid_o = done && (owner_q == OWN_DM);
    bus.if_rdata_o  = (done && (owner_q == OWN_IF)) ? bus.mem_rdata_i : {DATA_WIDTH{1'b0}};
    bus.dm_rdata_o  = (done && (owner_q == OWN_DM) && !store_q) ? bus.mem_rdata_i
                                                                 : {DATA_WIDTH{1'b0}};
  end

  // Port FSM: track the owner and remaining latency of the access in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      owner_q    <= OWN_NONE;
      busy_cnt_q <= '0;
      store_q    <= 1'b0;
    end else if (issue) begin
      state_q    <= ST_BUSY;
      owner_q    <= gnt_dm ? OWN_DM : OWN_IF;
      busy_cnt_q <= LAT_INIT;
      store_q    <= gnt_dm && bus.dm_we_i;
    end else if (state_q == ST_BUSY) begin
      if (done) begin
        state_q    <= ST_IDLE;
        owner_q    <= OWN_NONE;
        busy_cnt_q <= '0;
        store_q    <= 1'b0;
      end else begin
        busy_cnt_q <= busy_cnt_q - CNT_ONE;
      end
    end
  end

  // Count consecutive denied IF-request cycles, saturating at the limit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt_q <= '0;
    end else if (bus.if_req_i && !gnt_if) begin
      if (starve_cnt_q != STV_MAX) begin
        starve_cnt_q <= starve_cnt_q + STV_ONE;
      end
    end else begin
      starve_cnt_q <= '0;
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one non-pipelined, single-port unified memory between the IF stage (instruction fetch, read-only) and the MEM stage (load/store) of the 5-stage core.
- MEM stage has priority by default. A starvation counter guarantees IF forward progress.
- At most one transaction is outstanding. Response (rvalid) returns to the owner after a fixed MEM_LAT cycles.

Parameters:
DATA_WIDTH, 32, data bus width (bits)
ADDR_WIDTH, 10, word address width (1024-word memory)
MEM_LAT, 1, memory access latency in cycles (>=1); port busy for this long per access
STARVE_LIMIT, 4, consecutive denied IF-request cycles after which IF wins next arbitration

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
if_req_i  in  1  IF read request; held until granted
if_addr_i  in  ADDR_WIDTH  IF word address
if_gnt_o  out  1  IF request accepted this cycle (combinational)
if_rvalid_o  out  1  IF read data valid (one-cycle pulse)
if_rdata_o  out  DATA_WIDTH  IF read data; 0 when if_rvalid_o=0
dm_req_i  in  1  MEM-stage request; held until granted
dm_we_i  in  1  1=store, 0=load
dm_be_i  in  4  byte enables for store
dm_addr_i  in  ADDR_WIDTH  MEM-stage word address
dm_wdata_i  in  DATA_WIDTH  store data
dm_gnt_o  out  1  MEM-stage request accepted this cycle (combinational)
dm_rvalid_o  out  1  load data valid / store done (one-cycle pulse)
dm_rdata_o  out  DATA_WIDTH  load data; 0 for stores and when dm_rvalid_o=0
mem_en_o  out  1  memory access strobe (issue cycle only)
mem_we_o  out  1  memory write enable
mem_be_o  out  4  memory byte enables (4'b0000 for reads)
mem_addr_o  out  ADDR_WIDTH  memory address
mem_wdata_o  out  DATA_WIDTH  memory write data
mem_rdata_i  in  DATA_WIDTH  memory read data, valid MEM_LAT cycles after issue

Behaviour:
- Reset state: the FSM is in IDLE, busy_cnt=0, owner=NONE and starve_cnt=0.
- Reset outputs: all registered outputs are 0. mem_* are 0 because no grant is possible in reset. Any in-flight transaction is silently dropped, and no rvalid pulse follows reset deassertion.
- FSM states:
  - IDLE: port free.
  - BUSY: access outstanding. busy_cnt counts MEM_LAT down to 1. The owner register (IF/DM) records the requester.
- Arbitration window ("free"): the port is free in IDLE, or in BUSY when busy_cnt==1 (completion cycle). This gives back-to-back issue, so MEM_LAT=1 sustains one access per cycle.
- Winner selection when free:
  - dm_req_i wins, unless starve_cnt==STARVE_LIMIT and if_req_i=1, in which case IF wins.
  - Only one gnt per cycle. No request means no gnt and the FSM goes to IDLE after completion.
- Issue cycle t (gnt=1):
  - mem_en_o=1 and mem_addr/we/be/wdata come from the winner. IF forces we=0 and be=0.
  - State becomes BUSY, busy_cnt=MEM_LAT, owner=winner.
- Completion at cycle t+MEM_LAT:
  - The owner's rvalid_o=1 for exactly one cycle.
  - Owner's rdata_o = mem_rdata_i for loads/fetches, and 0 for stores.
  - The other requester's rvalid stays 0.
- Starvation counter (starve_cnt):
  - Increments (saturating at STARVE_LIMIT) each cycle where if_req_i=1 and if_gnt_o=0.
  - Clears on if_gnt_o=1, or when if_req_i=0.
- Simultaneous events: completion of an IF read and a new DM grant in the same cycle is legal. if_rvalid_o and dm_gnt_o are both 1, and the new mem_en_o is issued that cycle.
- Request withdrawal before gnt is not permitted (protocol violation, behaviour undefined). Address/data must be stable while req=1 and gnt=0.
- Both rvalid outputs are never 1 in the same cycle.
- mem_en_o is never 1 while busy_cnt>1.

Test Plan:
1. Reset with rst_n=0 while dm_req_i=1 -> all outputs 0 and no gnt; release rst_n -> dm_gnt_o=1 on the first active edge window; dm_rvalid_o one cycle later (MEM_LAT=1).
2. MEM_LAT=1, continuous if_req_i to addresses 0,1,2,3 with mem_rdata_i=addr+0x100 -> if_gnt_o=1 every cycle; if_rvalid_o=1 every cycle from the second; if_rdata_o=0x100..0x103 in order.
3. if_req_i and dm_req_i both high (load addr 0x20) -> dm_gnt_o=1 first; if_gnt_o=0; starve_cnt=1; IF granted next cycle once DM stops requesting.
4. STARVE_LIMIT=4, DM requests every cycle, IF constantly requesting -> IF denied exactly 4 cycles then granted on the 5th arbitration; DM stalls that cycle; starve_cnt returns to 0.
5. MEM_LAT=3, store dm_be_i=4'b0011, wdata=0xDEADBEEF, addr=5 -> mem_en_o/we/be asserted one cycle only; no gnt for 2 cycles; dm_rvalid_o pulse at t+3 with dm_rdata_o=0.
6. MEM_LAT=3, assert rst_n=0 at t+1 of an outstanding IF read -> no if_rvalid_o after reset release; FSM in IDLE; next request granted immediately.
